// File: rtl/mem_copy_engine_if.sv
// Bundled ports for the copy engine: a control-side request/status interface
// and the engine's driver-side view of the memory's read and write ports.

interface mem_copy_ctrl_if #(
  parameter int AW = 7,
  parameter int LW = 7
);
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, src_addr, dst_addr, len,
    input  busy, done, err
  );

  modport slave (
    input  start, src_addr, dst_addr, len,
    output busy, done, err
  );
endinterface

interface mem_copy_mem_if #(
  parameter int AW    = 7,
  parameter int WIDTH = 8
);
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/mem_copy_engine.sv
// memmove-style copy engine driving a one-cycle-latency memory: one read and
// one trailing write per cycle, direction chosen so overlapping ranges survive.

module mem_copy_engine #(
  parameter int DEPTH = 100,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  mem_copy_ctrl_if.slave  ctrl_if,
  mem_copy_mem_if.master  mem_if
);

  localparam int EW = LW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t        r_state;
  logic          r_desc;
  logic [AW-1:0] r_dst_ptr;
  logic [LW-1:0] r_remaining;

  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;

  // End addresses are one past the last word, widened so they cannot wrap.
  logic [EW-1:0] w_src_end;
  logic [EW-1:0] w_dst_end;
  logic          w_out_of_range;
  logic          w_len_zero;
  logic          w_desc;
  logic [AW-1:0] w_src_first;
  logic [AW-1:0] w_dst_first;

  assign w_src_end      = EW'(ctrl_if.src_addr) + EW'(ctrl_if.len);
  assign w_dst_end      = EW'(ctrl_if.dst_addr) + EW'(ctrl_if.len);
  assign w_out_of_range = (w_src_end > EW'(DEPTH)) || (w_dst_end > EW'(DEPTH));
  assign w_len_zero     = (ctrl_if.len == '0);

  // Copying upward into an overlapping range must start from the top end.
  assign w_desc      = (ctrl_if.dst_addr > ctrl_if.src_addr);
  assign w_src_first = w_desc ? AW'(w_src_end - EW'(1)) : ctrl_if.src_addr;
  assign w_dst_first = w_desc ? AW'(w_dst_end - EW'(1)) : ctrl_if.dst_addr;

  // NOTE: every register below is assigned with <= so all updates in this
  // block see pre-edge values, which is what keeps the write one step behind
  // the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_desc      <= 1'b0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctrl_if.start) begin
            if (w_len_zero) begin
              r_done  <= 1'b1;
              r_err   <= 1'b0;
              r_state <= S_FIN;
            end else if (w_out_of_range) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_desc      <= w_desc;
              r_rd_addr   <= w_src_first;
              r_dst_ptr   <= w_dst_first;
              r_remaining <= ctrl_if.len - LW'(1);
              r_rd_en     <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_RUN;
            end
          end
        end

        S_RUN: begin
          // The word read last cycle arrives now; write it where it belongs.
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_dst_ptr;
          if (r_remaining != '0) begin
            r_rd_addr   <= r_desc ? r_rd_addr - AW'(1) : r_rd_addr + AW'(1);
            r_dst_ptr   <= r_desc ? r_dst_ptr - AW'(1) : r_dst_ptr + AW'(1);
            r_remaining <= r_remaining - LW'(1);
          end else begin
            // Pointers hold on the last word so a descent to 0 never wraps.
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= 1'b0;
          r_state <= S_FIN;
        end

        S_FIN: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrl_if.busy = r_busy;
  assign ctrl_if.done = r_done;
  assign ctrl_if.err  = r_err;

  assign mem_if.rd_en   = r_rd_en;
  assign mem_if.rd_addr = r_rd_addr;
  assign mem_if.wr_en   = r_wr_en;
  assign mem_if.wr_addr = r_wr_addr;
  assign mem_if.wr_data = mem_if.rd_data;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: behavioural one-cycle-latency memory, a shadow model of
// its contents, and a cycle-stamped scoreboard of every expected read and write.

module tb_mem_copy_engine;

  localparam int DEPTH = 100;
  localparam int WIDTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int NOCUT = 1000000;

  typedef struct {
    int               cyc;
    int               addr;
    logic [WIDTH-1:0] data;
  } acc_t;

  logic clk;
  logic rst;

  mem_copy_ctrl_if #(.AW(AW), .LW(LW))       ctrl_if ();
  mem_copy_mem_if  #(.AW(AW), .WIDTH(WIDTH)) mem_if ();

  mem_copy_engine #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (ctrl_if),
    .mem_if  (mem_if)
  );

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] model [DEPTH];

  logic             pl_en;
  logic [AW-1:0]    pl_addr;
  logic [WIDTH-1:0] pl_data;

  acc_t rd_q[$];
  acc_t wr_q[$];

  int cyc;
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_if.wr_en) mem[mem_if.wr_addr] <= mem_if.wr_data;
    if (mem_if.rd_en) mem_if.rd_data <= mem[mem_if.rd_addr];
  end

  // Advance one clock, release the start pulse, then compare memory traffic
  // seen in the new cycle against the scoreboard.
  task automatic tick(input bit rst_mid);
    acc_t e;
    @(posedge clk);
    cyc++;
    #1;
    ctrl_if.start = 1'b0;
    if (rst_mid) rst = 1'b1;
    @(negedge clk);
    if (mem_if.rd_en === 1'b1) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read cyc=%0d: got read addr %0d, required no read", cyc, mem_if.rd_addr);
      end else begin
        e = rd_q.pop_front();
        if (e.cyc != cyc || e.addr != int'(mem_if.rd_addr)) begin
          n_fail++;
          $display("FAIL read: got cyc=%0d addr=%0d, required cyc=%0d addr=%0d", cyc, mem_if.rd_addr, e.cyc, e.addr);
        end
      end
    end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_read: got rd_en=%b at cyc=%0d, required read addr %0d", mem_if.rd_en, cyc, rd_q[0].addr);
      void'(rd_q.pop_front());
    end
    if (mem_if.wr_en === 1'b1) begin
      n_checks++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write cyc=%0d: got write addr %0d, required no write", cyc, mem_if.wr_addr);
      end else begin
        e = wr_q.pop_front();
        if (e.cyc != cyc || e.addr != int'(mem_if.wr_addr) || e.data !== mem_if.wr_data) begin
          n_fail++;
          $display("FAIL write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                   cyc, mem_if.wr_addr, mem_if.wr_data, e.cyc, e.addr, e.data);
        end
      end
    end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_write: got wr_en=%b at cyc=%0d, required write addr %0d", mem_if.wr_en, cyc, wr_q[0].addr);
      void'(wr_q.pop_front());
    end
  endtask

  task automatic preload(input int addr, input int val);
    pl_en   = 1'b1;
    pl_addr = AW'(addr);
    pl_data = WIDTH'(val);
    model[addr] = WIDTH'(val);
    tick(1'b0);
    pl_en = 1'b0;
  endtask

  // Drive a start request and push the traffic a memmove would generate.
  // Accesses in cycles at or after T<cut> are not expected (reset cuts them).
  task automatic launch(input int src, input int dst, input int len, input int cut, output int c);
    int               wa[$];
    logic [WIDTH-1:0] wd[$];
    int               off;
    bit               desc;
    c = cyc;
    ctrl_if.src_addr = AW'(src);
    ctrl_if.dst_addr = AW'(dst);
    ctrl_if.len      = LW'(len);
    ctrl_if.start    = 1'b1;
    if (len != 0 && src + len <= DEPTH && dst + len <= DEPTH) begin
      desc = (dst > src);
      for (int i = 0; i < len; i++) begin
        off = desc ? len - 1 - i : i;
        if (1 + i < cut) rd_q.push_back('{cyc: c + 1 + i, addr: src + off, data: '0});
        if (2 + i < cut) begin
          wr_q.push_back('{cyc: c + 2 + i, addr: dst + off, data: model[src + off]});
          wa.push_back(dst + off);
          wd.push_back(model[src + off]);
        end
      end
      foreach (wa[i]) model[wa[i]] = wd[i];
    end
  endtask

  task automatic wait_done(input int budget, input int poke_at, output int at, output logic e,
                           output int busy_first, output int busy_n);
    at = -1;
    e = 1'b0;
    busy_first = -1;
    busy_n = 0;
    for (int k = 0; k < budget; k++) begin
      if (cyc == poke_at) begin
        ctrl_if.start    = 1'b1;
        ctrl_if.src_addr = AW'(0);
        ctrl_if.dst_addr = AW'(90);
        ctrl_if.len      = LW'(2);
      end
      tick(1'b0);
      if (ctrl_if.busy === 1'b1) begin
        if (busy_first < 0) busy_first = cyc;
        busy_n++;
      end
      if (ctrl_if.done === 1'b1) begin
        at = cyc;
        e  = ctrl_if.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [2*AW+4:0] outs;
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    outs = {ctrl_if.busy, ctrl_if.done, ctrl_if.err, mem_if.rd_en, mem_if.wr_en, mem_if.rd_addr, mem_if.wr_addr};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    rst = 1'b0;
    tick(1'b0);
  endtask

  task automatic test_basic();
    int c, at, bf, bn;
    logic e;
    for (int i = 0; i < 4; i++) preload(2 + i, 1 + i);
    launch(2, 50, 4, NOCUT, c);
    wait_done(20, c + 3, at, e, bf, bn);
    n_checks++;
    if (at != c + 6 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got T%0d err=%b, required T6 err=0", at - c, e);
    end
    n_checks++;
    if (bf != c + 1 || bn != 5) begin
      n_fail++;
      $display("FAIL basic_busy: got first T%0d count %0d, required first T1 count 5", bf - c, bn);
    end
    tick(1'b0);
    n_checks++;
    if (ctrl_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later, required 0", ctrl_if.done);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[50 + i] !== WIDTH'(1 + i)) begin
        n_fail++;
        $display("FAIL basic_mem[%0d]: got %0d, required %0d", 50 + i, mem[50 + i], 1 + i);
      end
    end
  endtask

  task automatic test_overlap(input int src, input int dst, input int len, input int exp_base, input int exp_first);
    int c, at, bf, bn;
    logic e;
    for (int i = 10; i <= 14; i++) preload(i, i);
    launch(src, dst, len, NOCUT, c);
    wait_done(20, -1, at, e, bf, bn);
    n_checks++;
    if (at != c + len + 2 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL overlap_done src=%0d dst=%0d: got T%0d err=%b, required T%0d err=0", src, dst, at - c, e, len + 2);
    end
    for (int i = 0; i < len; i++) begin
      n_checks++;
      if (mem[exp_base + i] !== WIDTH'(exp_first + i)) begin
        n_fail++;
        $display("FAIL overlap_mem[%0d]: got %0d, required %0d", exp_base + i, mem[exp_base + i], exp_first + i);
      end
    end
    tick(1'b0);
  endtask

  task automatic test_short(input int src, input int dst, input int len, input logic exp_err);
    int c, at, bf, bn;
    logic e;
    launch(src, dst, len, NOCUT, c);
    wait_done(10, -1, at, e, bf, bn);
    n_checks++;
    if (at != c + 1 || e !== exp_err || bn != 0) begin
      n_fail++;
      $display("FAIL short src=%0d dst=%0d len=%0d: got done T%0d err=%b busy_cycles=%0d, required done T1 err=%b busy_cycles=0",
               src, dst, len, at - c, e, bn, exp_err);
    end
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic test_full();
    int c, at, bf, bn;
    logic e;
    launch(0, 0, 100, NOCUT, c);
    wait_done(120, -1, at, e, bf, bn);
    n_checks++;
    if (at != c + 102 || e !== 1'b0 || bn != 101) begin
      n_fail++;
      $display("FAIL full_copy: got done T%0d err=%b busy_cycles=%0d, required T102 err=0 busy_cycles=101", at - c, e, bn);
    end
    tick(1'b0);
  endtask

  task automatic test_back_to_back();
    int c, at, bf, bn;
    logic e;
    launch(30, 40, 3, NOCUT, c);
    wait_done(20, -1, at, e, bf, bn);
    n_checks++;
    if (at != c + 5) begin
      n_fail++;
      $display("FAIL b2b_first_done: got T%0d, required T5", at - c);
    end
    // A request raised while done is high lands in FIN and must be dropped.
    ctrl_if.start    = 1'b1;
    ctrl_if.src_addr = AW'(0);
    ctrl_if.dst_addr = AW'(80);
    ctrl_if.len      = LW'(2);
    tick(1'b0);
    launch(40, 44, 3, NOCUT, c);
    wait_done(20, -1, at, e, bf, bn);
    n_checks++;
    if (at != c + 5 || bf != c + 1) begin
      n_fail++;
      $display("FAIL b2b_second: got done T%0d busy from T%0d, required done T5 busy from T1", at - c, bf - c);
    end
    tick(1'b0);
  endtask

  task automatic test_reset_mid();
    int c, at, bf, bn;
    logic e;
    logic [2*AW+4:0] outs;
    for (int i = 0; i < 4; i++) preload(60 + i, 'hA0 + i);
    for (int i = 0; i < 4; i++) preload(20 + i, 'hEE);
    launch(60, 20, 4, 3, c);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    outs = {ctrl_if.busy, ctrl_if.done, ctrl_if.err, mem_if.rd_en, mem_if.wr_en, mem_if.rd_addr, mem_if.wr_addr};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h in T3, required 0", outs);
    end
    rst = 1'b0;
    tick(1'b0);
    tick(1'b0);
    n_checks++;
    if (mem[20] !== 8'hA0 || mem[21] !== 8'hEE || mem[22] !== 8'hEE || mem[23] !== 8'hEE) begin
      n_fail++;
      $display("FAIL midreset_mem: got %h %h %h %h, required a0 ee ee ee", mem[20], mem[21], mem[22], mem[23]);
    end
    launch(60, 70, 2, NOCUT, c);
    wait_done(20, -1, at, e, bf, bn);
    n_checks++;
    if (at != c + 4 || e !== 1'b0 || mem[70] !== 8'hA0 || mem[71] !== 8'hA1) begin
      n_fail++;
      $display("FAIL after_reset_copy: got done T%0d err=%b mem=%h %h, required T4 err=0 mem=a0 a1",
               at - c, e, mem[70], mem[71]);
    end
    tick(1'b0);
  endtask

  task automatic test_final_mem();
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== model[i]) begin
        bad++;
        $display("FAIL final_mem[%0d]: got %h, required %h", i, mem[i], model[i]);
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    n_checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d reads %0d writes pending, required 0 0", rd_q.size(), wr_q.size());
    end
  endtask

  initial begin
    cyc              = 0;
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    pl_en            = 1'b0;
    pl_addr          = '0;
    pl_data          = '0;
    ctrl_if.start    = 1'b0;
    ctrl_if.src_addr = '0;
    ctrl_if.dst_addr = '0;
    ctrl_if.len      = '0;

    test_reset();
    for (int i = 0; i < DEPTH; i++) preload(i, (i * 7 + 3) % 256);
    test_basic();
    test_overlap(10, 12, 5, 12, 10);
    test_overlap(12, 10, 3, 10, 12);
    test_short(98, 0, 3, 1'b1);
    test_short(0, 95, 10, 1'b1);
    test_short(5, 6, 0, 1'b0);
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_final_mem();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
